// File: rtl/rr_mux_stage.sv
// Registered N:1 mux, round-robin or static select; 1 clk latency; holds word while !out_ready, reloads on drain.
// Optional RR_MUX_LOCK_EN: per-channel packet lock via in_last/out_last.
module rr_mux_stage #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               force_en,
   input  logic [SELW-1:0]    force_sel,
`ifdef RR_MUX_LOCK_EN
   input  logic [N-1:0]       in_last,
   output logic               out_last,
`endif
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state, state_nxt;
   logic [SELW-1:0]   rr_ptr;
   logic [SELW-1:0]   grant;
   logic [SELW-1:0]   grant_nxt_ptr;
   logic              grant_vld;
   logic              load_ok;
   logic              xfer;
`ifdef RR_MUX_LOCK_EN
   logic              lock_vld;
   logic [SELW-1:0]   lock_ch;
`endif

   assign out_valid     = (state == FULL);
   assign load_ok       = !out_valid || out_ready;
   assign xfer          = grant_vld && load_ok;
   assign grant_nxt_ptr = (grant == SELW'(N-1)) ? '0 : grant + 1'b1;

   always_comb begin
      logic [SELW-1:0] idx;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      if (force_en) begin
         if (int'(force_sel) < N && in_valid[force_sel]) begin
            grant     = force_sel;
            grant_vld = 1'b1;
         end
      end else begin
`ifdef RR_MUX_LOCK_EN
         if (lock_vld) begin
            grant     = lock_ch;
            grant_vld = in_valid[lock_ch];
         end else
`endif
         begin
            // Scan farthest-first so the channel nearest rr_ptr wins last.
            for (int k = N-1; k >= 0; k--) begin
               idx = SELW'((int'(rr_ptr) + k) % N);
               if (in_valid[idx]) begin
                  grant     = idx;
                  grant_vld = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && xfer)
         in_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (xfer) state_nxt = FULL;
         FULL:  if (out_ready && !xfer) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
         rr_ptr   <= '0;
`ifdef RR_MUX_LOCK_EN
         out_last <= 1'b0;
         lock_vld <= 1'b0;
         lock_ch  <= '0;
`endif
      end else begin
         if (xfer) begin
            out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel  <= grant;
         end
`ifdef RR_MUX_LOCK_EN
         if (xfer)
            out_last <= in_last[grant];
         if (force_en) begin
            lock_vld <= 1'b0;
         end else if (xfer) begin
            lock_vld <= !in_last[grant];
            lock_ch  <= grant;
            // The pointer only moves once the whole packet has gone through.
            if (in_last[grant])
               rr_ptr <= grant_nxt_ptr;
         end
`else
         if (xfer && !force_en)
            rr_ptr <= grant_nxt_ptr;
`endif
      end
   end

endmodule

// File: tb/tb_rr_mux_stage.sv
// Bench for rr_mux_stage: directed scenarios plus random traffic against a queue-free reference model.
module tb_rr_mux_stage;
   localparam int N = 4;
   localparam int W = 16;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           force_en;
   logic [S-1:0]   force_sel;
   logic [W-1:0]   out_data;
   logic [S-1:0]   out_sel;
   logic           out_valid;
   logic           out_ready;
`ifdef RR_MUX_LOCK_EN
   logic [N-1:0]   in_last;
   logic           out_last;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   bit       m_vld;
   bit [W-1:0] m_dat;
   int       m_sel;
   int       m_ptr;
   bit       m_lock;
   int       m_lch;
   bit       m_last;

   rr_mux_stage #(.WIDTH(W), .N(N), .SELW(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .force_en  (force_en),
      .force_sel (force_sel),
`ifdef RR_MUX_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Grant = valid channel at the smallest forward distance from the pointer.
   function automatic int model_grant();
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = N;
      if (force_en)
         return (int'(force_sel) < N && in_valid[force_sel]) ? int'(force_sel) : -1;
`ifdef RR_MUX_LOCK_EN
      if (m_lock)
         return in_valid[m_lch] ? m_lch : -1;
`endif
      for (int i = 0; i < N; i++) begin
         if (in_valid[i]) begin
            d = (i - m_ptr + N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_vld = 0; m_dat = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lch = 0; m_last = 0;
   endtask

   // Called at a negedge with fresh inputs applied; returns at the next negedge.
   task automatic cycle();
      int g;
      logic [N-1:0] er;
      bit ok;
      #1;
      g  = model_grant();
      ok = (g >= 0) && (!m_vld || out_ready);
      er = '0;
      if (ok) er[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (ok) begin
         m_vld = 1;
         m_dat = in_data[g*W +: W];
         m_sel = g;
`ifdef RR_MUX_LOCK_EN
         m_last = in_last[g];
         if (!force_en) begin
            m_lock = !in_last[g];
            m_lch  = g;
            if (in_last[g]) m_ptr = (g + 1) % N;
         end
`else
         if (!force_en) m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
         m_vld = 0;
      end
      if (force_en) m_lock = 0;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("out_data", 32'(out_data), 32'(m_dat));
      chk("out_sel", 32'(out_sel), 32'(m_sel));
`ifdef RR_MUX_LOCK_EN
      chk("out_last", 32'(out_last), 32'(m_last));
`endif
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_sel", 32'(out_sel), 0);
      chk("rst_ready", 32'(in_ready), 0);
`ifdef RR_MUX_LOCK_EN
      chk("rst_last", 32'(out_last), 0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_ch(input int ch, input logic [W-1:0] v);
      in_data[ch*W +: W] = v;
   endtask

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = '0; force_en = 1'b0;
      force_sel = '0; out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
      in_last = '1;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      chk("init_valid", 32'(out_valid), 0);
      chk("init_ready", 32'(in_ready), 0);
      rst_n = 1'b1;

      // Round robin, all valid, no bubbles
      set_ch(0, 16'hAAAA); set_ch(1, 16'h1111); set_ch(2, 16'h5555); set_ch(3, 16'h0000);
      in_valid = 4'hF; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("rr_seq", 32'(out_sel), 32'(k % 4));
         chk("rr_valid", 32'(out_valid), 1);
      end
      cycle();
      chk("rr_to3", 32'(out_sel), 2);

      // Sparse wrap from pointer 3
      in_valid = 4'b0010;
      cycle();
      chk("wrap_sel", 32'(out_sel), 1);
      chk("wrap_data", 32'(out_data), 'h1111);
      in_valid = 4'hF;
      cycle();
      chk("wrap_next", 32'(out_sel), 2);

      // Backpressure
      force_en = 1'b1; force_sel = 2'd0; set_ch(0, 16'h1234);
      cycle();
      chk("bp_load", 32'(out_data), 'h1234);
      force_en = 1'b0; out_ready = 1'b0; set_ch(0, 16'hBEEF);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_data", 32'(out_data), 'h1234);
         chk("bp_sel", 32'(out_sel), 0);
         chk("bp_rdy", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_reload_v", 32'(out_valid), 1);
      chk("bp_reload_sel", 32'(out_sel), 3);

      // Static select
      set_ch(0, 16'hAAAA); force_en = 1'b1; force_sel = 2'd2;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("static_data", 32'(out_data), 'h5555);
         chk("static_sel", 32'(out_sel), 2);
         chk("static_rdy", 32'(in_ready), 'b0100);
      end

      // Reset mid-stream with a word held
      do_reset();
      force_en = 1'b0;

`ifdef RR_MUX_LOCK_EN
      in_valid = 4'b0011;
      for (int b = 0; b < 3; b++) begin
         in_last = {2'b00, 1'b1, (b == 2)};
         cycle();
         chk("lock_sel", 32'(out_sel), 0);
         chk("lock_last", 32'(out_last), 32'(b == 2));
      end
      cycle();
      chk("lock_rel_sel", 32'(out_sel), 1);
      chk("lock_rel_last", 32'(out_last), 1);
`endif

      for (int c = 0; c < 3000; c++) begin
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         force_en  = ($urandom_range(0, 9) == 0);
         force_sel = 2'($urandom);
         if ($urandom_range(0, 1) == 1) in_data = {$urandom(), $urandom()};
`ifdef RR_MUX_LOCK_EN
         in_last = 4'($urandom);
`endif
         cycle();
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
